clk_meter: RTL and testbench
============================

CLK_METER -- requirements
Module: clk_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of every count output and internal counter.
REQ-002 Parameter TIMEOUT, default 1000, clk cycles without a detected sig edge before STUCK.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth on sig_in (legal 2..4).
REQ-004 clk  input  1  sampling clock; all state on rising edge; the block uses one clock only.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  measurement enable.
REQ-007 sig_in  input  1  asynchronous clock-like signal under measurement.
REQ-008 ref_tick  input  1  single-cycle phase-reference pulse, synchronous to clk.
REQ-009 ton  output  CNT_W  high-time of the last complete period, in clk cycles.
REQ-010 toff  output  CNT_W  low-time of the last complete period, in clk cycles.
REQ-011 period  output  CNT_W  ton+toff of the last complete period.
REQ-012 meas_valid  output  1  one-cycle pulse when ton/toff/period update.
REQ-013 phase  output  CNT_W  cycles from ref_tick to the next detected sig rising edge.
REQ-014 phase_valid  output  1  one-cycle pulse when phase updates.
REQ-015 stuck  output  1  level; high while in STUCK.

Function
REQ-016 sig_in SHALL pass through SYNC_STAGES flops; rise/fall SHALL be detected by comparing the last stage with one further registered copy.
REQ-017 Detection latency SHALL be SYNC_STAGES+1 clk cycles from the sig_in transition to the rise/fall strobe.
REQ-018 FSM states: IDLE, ARM, HIGH, LOW, STUCK.
REQ-019 IDLE: en=0; counters held at 0; en=1 -> ARM next cycle.
REQ-020 ARM: wait for the first rise -> HIGH with hi_cnt=1; a partial first period SHALL never be reported.
REQ-021 HIGH: hi_cnt increments each cycle; fall -> LOW with lo_cnt=1.
REQ-022 LOW: lo_cnt increments; rise -> HIGH with hi_cnt=1, and in that same cycle ton<=hi_cnt, toff<=lo_cnt, period<=hi_cnt+lo_cnt, meas_valid=1 for one cycle.
REQ-023 Counters SHALL saturate at 2^CNT_W-1; period SHALL saturate, never wrap.
REQ-024 In ARM/HIGH/LOW, an edge-free interval reaching TIMEOUT cycles SHALL go STUCK with stuck=1; no meas_valid.
REQ-025 STUCK: the next rise -> HIGH with hi_cnt=1 and stuck=0; the previous ton/toff/period are held.
REQ-026 Phase: ref_tick SHALL clear ph_cnt and set ph_busy; while ph_busy, ph_cnt increments; the next rise SHALL load phase<=ph_cnt, pulse phase_valid, and clear ph_busy.
REQ-027 ref_tick and rise in the same cycle: phase=0, phase_valid=1, ph_busy cleared.
REQ-028 A second ref_tick while ph_busy SHALL restart ph_cnt at 0; no output.
REQ-029 Phase measurement SHALL run in every state except IDLE; the rise strobe counts even in ARM/STUCK.
REQ-030 en falling SHALL go to IDLE next cycle, clearing ph_busy and stuck; ton/toff/period/phase are held.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state IDLE; all counters 0; ton=toff=period=phase=0; meas_valid=phase_valid=stuck=0; synchronizer flops 0.
REQ-032 Reset during a measurement SHALL discard the period in progress; after release the block re-arms per REQ-019/020.

Structure
REQ-033 Package clk_meter_pkg SHALL hold the FSM state enum and the default CNT_W/TIMEOUT constants.
REQ-034 Sub-module sig_sync_edge SHALL contain the synchronizer and the rise/fall detector.

Verification
REQ-035 clk 100 MHz, sig_in ton=30 ns, toff=70 ns, en=1 -> from the second rise on: ton=3, toff=7, period=10, meas_valid once per sig period.
REQ-036 sig_in held low after 5 periods, TIMEOUT=50 -> stuck=1 on the 50th edge-free cycle; outputs hold 3/7/10; the next rise clears stuck; the next full period reports again.
REQ-037 ref_tick then sig rise 4 cycles later at the strobe -> phase=4, phase_valid pulse; ref_tick coincident with the rise strobe -> phase=0.
REQ-038 CNT_W=4, ton=20 cycles -> ton=15 (saturated), period saturated at 15.
REQ-039 rst_n pulsed low mid-HIGH -> all outputs 0 immediately; the first meas_valid arrives only after a full rise-to-rise period.
REQ-040 en dropped mid-LOW -> IDLE, no meas_valid, last values held; en re-raised -> ARM, no report until a complete period.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: shared state encoding and default sizing for the clock meter
package clk_meter_pkg;
    typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, STUCK} state_t;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1000;
endpackage

// File: rtl/sig_sync_edge.sv
// sig_sync_edge: synchronizes an asynchronous signal and strobes its edges
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   last;
    // metastability chain plus one delayed copy of its last stage for the edge compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            last <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            last <= sync[SYNC_STAGES-1];
        end
    end
    assign rise = sync[SYNC_STAGES-1] & ~last;
    assign fall = ~sync[SYNC_STAGES-1] & last;
endmodule

// File: rtl/clk_meter.sv
// clk_meter: measures high/low time, period and reference phase of an async signal
module clk_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    input  logic             ref_tick,
    output logic [CNT_W-1:0] ton,
    output logic [CNT_W-1:0] toff,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic [CNT_W-1:0] phase,
    output logic             phase_valid,
    output logic             stuck
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t           state, nxt;
    logic             rise, fall, edge_any, active, to_hit;
    logic [CNT_W-1:0] hi_cnt, lo_cnt, ph_cnt, per_sat;
    logic [CNT_W:0]   sum;
    logic [TW-1:0]    tmo_cnt;
    logic             ph_busy;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign edge_any = rise | fall;
    assign active   = en && (state != IDLE);
    assign to_hit   = !edge_any && (tmo_cnt >= TMO_LAST);
    assign sum      = {1'b0, hi_cnt} + {1'b0, lo_cnt};
    assign per_sat  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // next state: en low always returns to IDLE; an edge beats the timeout
    always_comb begin
        nxt = state;
        if (!en) nxt = IDLE;
        else begin
            case (state)
                IDLE:    nxt = ARM;
                ARM:     nxt = rise ? HIGH : to_hit ? STUCK : ARM;
                HIGH:    nxt = fall ? LOW  : to_hit ? STUCK : HIGH;
                LOW:     nxt = rise ? HIGH : to_hit ? STUCK : LOW;
                STUCK:   nxt = rise ? HIGH : STUCK;
                default: nxt = IDLE;
            endcase
        end
    end

    // stuck is a pure decode of the state
    always_comb begin
        stuck = (state == STUCK);
    end

    // counters, measurement results and phase tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            tmo_cnt     <= '0;
            ton         <= '0;
            toff        <= '0;
            period      <= '0;
            meas_valid  <= 1'b0;
            ph_cnt      <= '0;
            ph_busy     <= 1'b0;
            phase       <= '0;
            phase_valid <= 1'b0;
        end else begin
            meas_valid  <= 1'b0;
            phase_valid <= 1'b0;
            tmo_cnt     <= (!active || state == STUCK || edge_any) ? '0 : tmo_cnt + 1'b1;
            if (!active) begin
                hi_cnt  <= '0;
                lo_cnt  <= '0;
                ph_cnt  <= '0;
                ph_busy <= 1'b0;
            end else begin
                case (state)
                    ARM, STUCK: if (rise) hi_cnt <= ONE;
                    HIGH: begin
                        if (fall)         lo_cnt <= ONE;
                        else if (!to_hit) hi_cnt <= sat_inc(hi_cnt);
                    end
                    LOW: begin
                        if (rise) begin
                            ton        <= hi_cnt;
                            toff       <= lo_cnt;
                            period     <= per_sat;
                            meas_valid <= 1'b1;
                            hi_cnt     <= ONE;
                        end else if (!to_hit) lo_cnt <= sat_inc(lo_cnt);
                    end
                    default: ;
                endcase
                if (ref_tick && rise) begin
                    phase       <= '0;
                    phase_valid <= 1'b1;
                    ph_busy     <= 1'b0;
                end else if (ref_tick) begin
                    ph_cnt  <= '0;
                    ph_busy <= 1'b1;
                end else if (ph_busy) begin
                    if (rise) begin
                        phase       <= sat_inc(ph_cnt);
                        phase_valid <= 1'b1;
                        ph_busy     <= 1'b0;
                    end else ph_cnt <= sat_inc(ph_cnt);
                end
            end
        end
    end
endmodule

// File: tb/tb_clk_meter.sv
// tb_clk_meter: directed checks of period, timeout, phase, saturation, reset and enable
module tb_clk_meter;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, sig_in = 1'b0, ref_tick = 1'b0;
    logic [15:0] ton, toff, period, phase;
    logic        meas_valid, phase_valid, stuck;
    logic [3:0]  ton4, toff4, period4, phase4;
    logic        mv4, pv4, stuck4;
    int          total = 0, bad = 0, mv_cnt = 0, pv_cnt = 0, mv0 = 0;

    always #5 clk = ~clk;

    clk_meter #(.CNT_W(16), .TIMEOUT(50), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .ref_tick(ref_tick),
        .ton(ton), .toff(toff), .period(period), .meas_valid(meas_valid),
        .phase(phase), .phase_valid(phase_valid), .stuck(stuck)
    );

    clk_meter #(.CNT_W(4), .TIMEOUT(50), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .ref_tick(ref_tick),
        .ton(ton4), .toff(toff4), .period(period4), .meas_valid(mv4),
        .phase(phase4), .phase_valid(pv4), .stuck(stuck4)
    );

    // count valid pulses once per cycle, just after the edge that drives them
    always @(posedge clk) begin
        #1;
        if (meas_valid) mv_cnt++;
        if (phase_valid) pv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sp(input int h, input int l);
        sig_in = 1'b1;
        cyc(h);
        sig_in = 1'b0;
        cyc(l);
    endtask

    task automatic pulse_ref();
        ref_tick = 1'b1;
        cyc(1);
        ref_tick = 1'b0;
    endtask

    initial begin
        cyc(2);
        check("rst_mv", 32'(meas_valid), 0);
        check("rst_stuck", 32'(stuck), 0);
        check("rst_ton", 32'(ton), 0);
        check("rst_period", 32'(period), 0);
        check("rst_phase", 32'(phase), 0);
        rst_n = 1'b1;
        cyc(1);
        en = 1'b1;
        cyc(3);

        repeat (5) sp(3, 7);
        cyc(6);
        check("base_mv_cnt", 32'(mv_cnt), 4);
        check("base_ton", 32'(ton), 3);
        check("base_toff", 32'(toff), 7);
        check("base_period", 32'(period), 10);
        check("base_ton4", 32'(ton4), 3);
        check("base_stuck", 32'(stuck), 0);

        cyc(25);
        check("pre_stuck", 32'(stuck), 0);
        cyc(25);
        check("stuck_set", 32'(stuck), 1);
        check("stuck_ton", 32'(ton), 3);
        check("stuck_toff", 32'(toff), 7);
        check("stuck_period", 32'(period), 10);
        check("stuck_mv_cnt", 32'(mv_cnt), 4);

        sp(3, 7);
        check("unstuck", 32'(stuck), 0);
        check("unstuck_norep", 32'(mv_cnt), 4);
        sp(4, 6);
        sig_in = 1'b1;
        cyc(5);
        check("rep_mv_cnt", 32'(mv_cnt), 6);
        check("rep_ton", 32'(ton), 4);
        check("rep_toff", 32'(toff), 6);
        check("rep_period", 32'(period), 10);

        sig_in = 1'b0;
        cyc(10);
        pulse_ref();
        cyc(1);
        sig_in = 1'b1;
        cyc(6);
        check("phase4", 32'(phase), 4);
        check("phase4_pv", 32'(pv_cnt), 1);

        sig_in = 1'b0;
        cyc(10);
        sig_in = 1'b1;
        cyc(2);
        pulse_ref();
        cyc(4);
        check("phase0", 32'(phase), 0);
        check("phase0_pv", 32'(pv_cnt), 2);

        sig_in = 1'b0;
        cyc(10);
        pulse_ref();
        cyc(4);
        pulse_ref();
        sig_in = 1'b1;
        cyc(6);
        check("phase_restart", 32'(phase), 3);
        check("phase_restart_pv", 32'(pv_cnt), 3);

        sig_in = 1'b0;
        cyc(10);
        sp(20, 7);
        sig_in = 1'b1;
        cyc(5);
        check("wide_ton", 32'(ton), 20);
        check("wide_period", 32'(period), 27);
        check("sat_ton4", 32'(ton4), 15);
        check("sat_toff4", 32'(toff4), 7);
        check("sat_period4", 32'(period4), 15);

        cyc(5);
        rst_n = 1'b0;
        #1;
        check("arst_ton", 32'(ton), 0);
        check("arst_period", 32'(period), 0);
        check("arst_phase", 32'(phase), 0);
        check("arst_ton4", 32'(ton4), 0);
        cyc(2);
        sig_in = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        mv0 = mv_cnt;
        cyc(7);
        sp(5, 5);
        check("arst_norep", 32'(mv_cnt - mv0), 0);
        sig_in = 1'b1;
        cyc(5);
        check("arst_rep", 32'(mv_cnt - mv0), 1);
        check("arst_ton_new", 32'(ton), 5);
        check("arst_toff_new", 32'(toff), 5);

        sig_in = 1'b0;
        cyc(3);
        en = 1'b0;
        cyc(2);
        sig_in = 1'b1;
        cyc(5);
        check("en_off_norep", 32'(mv_cnt - mv0), 1);
        check("en_off_hold", 32'(ton), 5);
        check("en_off_stuck", 32'(stuck), 0);
        en = 1'b1;
        cyc(2);
        sig_in = 1'b0;
        cyc(5);
        sp(6, 4);
        check("en_on_norep", 32'(mv_cnt - mv0), 1);
        sig_in = 1'b1;
        cyc(5);
        check("en_on_rep", 32'(mv_cnt - mv0), 2);
        check("en_on_ton", 32'(ton), 6);
        check("en_on_toff", 32'(toff), 4);
        check("en_on_period", 32'(period), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
